counter_scheduler: RTL and testbench

- Round-robin scheduler that shares one `counter` instance (CW-bit up-counter) between NREQ requesters.
- Each requester asks for a timed run of `len` counts. The scheduler grants the counter, clears it, enables it until it reaches `len`, then signals done and rearbitrates.
- Sits beside the counter, between the counter and the blocks needing interval timing.
- Counter contract:
  - synchronous active-high reset to 0;
  - +1 per clock while enable is high;
  - wraps modulo 2^CW;
  - output registered.

---
 rtl/counter_scheduler.sv | 133 +++++++++++++
 tb/tb_counter_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - round-robin scheduler sharing one up-counter between requesters
// Also holds the shared up-counter the scheduler drives.

module counter #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] value
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (enable) begin
      value <= value + 1'b1;
    end
  end

endmodule

module counter_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int IW   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len_flat,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [IW-1:0]      owner,
  output logic               cnt_reset,
  output logic               cnt_enable,
  input  logic [CW-1:0]      cnt_value
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner_q;
  logic [CW-1:0]   target;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;

  logic            pick_valid;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   next_ptr;
  logic            owner_req;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    scan_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = IW'((int'(ptr) + i) % NREQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  assign next_ptr  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_req = req[owner_q];

  assign cnt_reset  = reset | (state == S_CLEAR);
  assign cnt_enable = (state == S_RUN) && (cnt_value != target) && owner_req;
  assign busy       = (state != S_IDLE);
  assign grant      = grant_q;
  assign done       = done_q;
  assign owner      = owner_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      owner_q <= '0;
      target  <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q  <= '0;
          grant_q <= '0;
          if (pick_valid) begin
            owner_q <= pick;
            target  <= len_flat[int'(pick)*CW +: CW];
            grant_q <= NREQ'(1) << pick;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!owner_req) begin
            grant_q <= '0;
            ptr     <= next_ptr;
            state   <= S_IDLE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // A dropped request aborts even on the terminal count cycle.
          if (!owner_req) begin
            grant_q <= '0;
            ptr     <= next_ptr;
            state   <= S_IDLE;
          end else if (cnt_value == target) begin
            done_q <= NREQ'(1) << owner_q;
            state  <= S_DONE;
          end
        end
        default: begin
          done_q  <= '0;
          grant_q <= '0;
          ptr     <= next_ptr;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - self-checking bench for counter_scheduler with a timeline model
// The model predicts each run as a schedule relative to its arbitration cycle.

module tb_counter_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ*CW-1:0] len_flat = '0;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             busy;
  logic [IW-1:0]    owner;
  logic             cnt_reset;
  logic             cnt_enable;
  logic [CW-1:0]    cnt_value;

  always #5 clock = ~clock;

  counter_scheduler #(.NREQ(NREQ), .CW(CW), .IW(IW)) dut (
    .clock(clock), .reset(reset), .req(req), .len_flat(len_flat),
    .grant(grant), .done(done), .busy(busy), .owner(owner),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .cnt_value(cnt_value)
  );

  counter #(.CW(CW)) u_cnt (
    .clock(clock), .reset(cnt_reset), .enable(cnt_enable), .value(cnt_value)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a run arbitrated at cycle m_start has CLEAR at +1, RUN at +2..+target+2, DONE at +target+3.
  int cyc = 0;
  bit m_valid = 0;
  bit m_run = 0;
  int m_start, m_owner, m_ptr, m_target;
  int en_count, rst_count, done_count;
  int gq[$];
  int gcyc[$];
  logic [NREQ-1:0] prev_grant = '0;

  always @(negedge clock) begin
    int rel, idx, exp_cnt;
    bit active;
    logic [NREQ-1:0] exp_grant;
    cyc++;
    rel    = cyc - m_start;
    active = m_run && rel >= 1;
    if (m_valid) begin
      exp_grant = active ? (NREQ'(1) << m_owner) : '0;
      check("grant", int'(grant), int'(exp_grant));
      check("done", int'(done), (active && rel == m_target + 3) ? int'(exp_grant) : 0);
      check("busy", int'(busy), int'(active));
      check("owner", int'(owner), m_owner);
      check("cnt_reset", int'(cnt_reset), int'(reset || (active && rel == 1)));
      check("cnt_enable", int'(cnt_enable),
            int'(active && rel >= 2 && rel <= m_target + 1 && req[m_owner]));
      if (active && rel >= 2) begin
        exp_cnt = (rel - 2 < m_target) ? rel - 2 : m_target;
        check("cnt_value", int'(cnt_value), exp_cnt);
      end
    end
    if (cnt_enable) en_count++;
    if (cnt_reset) rst_count++;
    if (done != 0) done_count++;
    if (grant != 0 && prev_grant == 0) begin
      for (int i = 0; i < NREQ; i++) if (grant[i]) gq.push_back(i);
      gcyc.push_back(cyc);
    end
    prev_grant = grant;
    if (reset) begin
      m_valid = 1;
      m_run   = 0;
      m_ptr   = 0;
      m_owner = 0;
    end else if (m_valid) begin
      if (active) begin
        if ((rel <= m_target + 2 && !req[m_owner]) || rel == m_target + 3) begin
          m_run = 0;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end else if (req != 0) begin
        for (int i = NREQ - 1; i >= 0; i--) begin
          idx = (m_ptr + i) % NREQ;
          if (req[idx]) m_owner = idx;
        end
        m_target = int'(len_flat[m_owner*CW +: CW]);
        m_start  = cyc;
        m_run    = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    en_count = 0; rst_count = 0; done_count = 0;
    gq.delete(); gcyc.delete();
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done == 0 && n < limit);
    if (done == 0) check("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check("wait_idle", int'(busy), 0);
  endtask

  task automatic tick_until_cnt(input string name, input int val);
    int n = 0;
    while (int'(cnt_value) != val && n < 50) begin tick(); n++; end
    check(name, int'(cnt_value), val);
  endtask

  task automatic wait_grants(input int cnt);
    int n = 0;
    while (gq.size() < cnt && n < 200) begin tick(); n++; end
    check("wait_grants", gq.size(), cnt);
  endtask

  initial begin
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    // 1: single run, len 5
    do_reset();
    check("reset_grant", int'(grant), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_owner", int'(owner), 0);
    len_flat[3:0] = 4'd5;
    req = 4'b0001;
    @(negedge clock);
    check("t1_grant_idle", int'(grant), 0);
    @(negedge clock);
    check("t1_grant_next", int'(grant), 1);
    wait_done(30, n);
    check("t1_done_latency", 1 + n, 8);
    check("t1_done_value", int'(done), 1);
    check("t1_cnt_at_done", int'(cnt_value), 5);
    check("t1_enable_cycles", en_count, 5);
    check("t1_cnt_reset_pulses", rst_count, 1);
    tick();
    req = 4'b0000;
    @(negedge clock);
    check("t1_grant_dropped", int'(grant), 0);
    check("t1_cnt_held", int'(cnt_value), 5);
    tick();

    // 2: all requesting, len 2 each
    do_reset();
    len_flat = 16'h2222;
    req = 4'b1111;
    wait_grants(5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("t2_order", gq[i], exp_order[i]);
    for (int i = 0; i + 1 < 5 && i + 1 < gcyc.size(); i++)
      check("t2_grant_period", gcyc[i+1] - gcyc[i], 6);
    req = 4'b0000;
    wait_idle();

    // 3: zero-length run
    len_flat = 16'h0000;
    tick();
    en_count = 0;
    req = 4'b0010;
    wait_done(20, n);
    check("t3_done_latency", n - 1, 3);
    check("t3_done_value", int'(done), 2);
    check("t3_cnt_value", int'(cnt_value), 0);
    check("t3_enable_cycles", en_count, 0);
    tick();
    req = 4'b0000;
    wait_idle();

    // 4: abort mid-run, then pointer wraps past 3 to 0
    len_flat = 16'h0F00;
    done_count = 0;
    req = 4'b0100;
    tick_until_cnt("t4_reach7", 7);
    req = 4'b0000;
    en_count = 0;
    repeat (4) tick();
    check("t4_no_done", done_count, 0);
    check("t4_grant_zero", int'(grant), 0);
    check("t4_cnt_stopped", int'(cnt_value == 4'd7 || cnt_value == 4'd8), 1);
    check("t4_no_enable", en_count, 0);
    gq.delete(); gcyc.delete();
    req = 4'b0101;
    wait_grants(1);
    if (gq.size() > 0) check("t4_wrap_grant", gq[0], 0);
    req = 4'b0000;
    wait_idle();

    // 5: reset mid-run, then a fresh run
    len_flat = 16'h0009;
    tick();
    req = 4'b0001;
    tick_until_cnt("t5_reach4", 4);
    done_count = 0;
    reset = 1'b1;
    tick();
    check("t5_grant", int'(grant), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_cnt", int'(cnt_value), 0);
    check("t5_no_done", done_count, 0);
    reset = 1'b0;
    wait_done(40, n);
    check("t5_done_latency", n - 1, 12);
    check("t5_cnt_at_done", int'(cnt_value), 9);
    tick();
    req = 4'b0000;
    wait_idle();

    // 6: len change mid-run ignored, new requester served first
    len_flat = 16'h0006;
    tick();
    req = 4'b0001;
    tick_until_cnt("t6_reach2", 2);
    len_flat = 16'h0002;
    req = 4'b1001;
    wait_done(30, n);
    check("t6_done_value", int'(done), 1);
    check("t6_cnt_at_done", int'(cnt_value), 6);
    gq.delete(); gcyc.delete();
    wait_grants(1);
    if (gq.size() > 0) check("t6_next_grant", gq[0], 3);
    req = 4'b0000;
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
